// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer and a synchronous flush.
// Optional stall-cycle counter port is built when PIPE_STAGE_SKID_STALL_CNT_EN is defined.
module pipe_stage_skid #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [CTRL_W-1:0]       ctrl_i,
    input  logic [LANES*DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]       rd_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CTRL_W-1:0]       ctrl_o,
    output logic [LANES*DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0]       rd_o,
    output logic [1:0]              occ_o
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]        stall_cnt_o
`endif
);

    // state | meaning
    // EMPTY | main invalid, skid invalid
    // ONE   | main valid, skid invalid
    // FULL  | main and skid valid, upstream stalled
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int PAY_W = LANES * DATA_W;

    state_t              state;
    logic [CTRL_W-1:0]   main_ctrl;
    logic [PAY_W-1:0]    main_data;
    logic [ADDR_W-1:0]   main_rd;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic [PAY_W-1:0]    skid_data;
    logic [ADDR_W-1:0]   skid_rd;
    logic                in_ready_r;
    logic                accept;
    logic                issue;

    assign accept = in_valid_i & in_ready_r;
    assign issue  = (state != EMPTY) & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= EMPTY;
            in_ready_r <= 1'b1;
            main_ctrl  <= '0;
            main_data  <= '0;
            main_rd    <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            skid_rd    <= '0;
        end else if (flush_i) begin
            // Data and rd are left as-is; ctrl=0 is what makes the bubble harmless.
            state      <= EMPTY;
            in_ready_r <= 1'b1;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_ctrl <= ctrl_i;
                        main_data <= data_i;
                        main_rd   <= rd_i;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        main_ctrl <= ctrl_i;
                        main_data <= data_i;
                        main_rd   <= rd_i;
                    end else if (accept) begin
                        skid_ctrl  <= ctrl_i;
                        skid_data  <= data_i;
                        skid_rd    <= rd_i;
                        in_ready_r <= 1'b0;
                        state      <= FULL;
                    end else if (issue) begin
                        main_ctrl <= '0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (issue) begin
                        main_ctrl  <= skid_ctrl;
                        main_data  <= skid_data;
                        main_rd    <= skid_rd;
                        skid_ctrl  <= '0;
                        in_ready_r <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    main_ctrl  <= '0;
                    skid_ctrl  <= '0;
                    in_ready_r <= 1'b1;
                    state      <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = (state != EMPTY);
    assign occ_o       = state;
    assign ctrl_o      = main_ctrl;
    assign data_o      = main_data;
    assign rd_o        = main_rd;

`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating; flush deliberately does not clear it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
